load_store_unit: RTL
====================

# load_store_unit

Initiator side of the data-memory port in the RISC-V core. Accepts one load/store request at a time from the execute/memory stage and drives the word-addressed data memory (`addy`, `datain`, `wen`, `ren`, `byte_selector`, `dataout`). Generates byte lanes and store-data alignment, and extracts and sign-extends load data. Returns each result through a valid/ready response. Out-of-range and misaligned accesses are resolved here; they never reach the memory.

## Interface
Parameters:
- `MEM_WORDS`, 1024: number of 32-bit words in data memory. Legal word index is 0..MEM_WORDS-1.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the unit can accept a request (high only in IDLE).
- `req_wr` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3. Loads: LB/LH/LW/LBU/LHU. Stores: SB/SH/SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_rd` in 5: destination register tag, returned unchanged.
- `resp_valid` out 1: a response is present.
- `resp_ready` in 1: the consumer accepts the response.
- `resp_rdata` out 32: extended load data. 0 for stores and errors.
- `resp_rd` out 5: echoed tag.
- `resp_err_misaligned` out 1: the access was misaligned and not performed.
- `resp_err_range` out 1: the access was out of range and not performed.
- `mem_addy` out 32: word index, `addr[31:2]` zero-extended.
- `mem_datain` out 32: lane-aligned store data.
- `mem_wen` out 1: memory write enable.
- `mem_ren` out 1: memory read enable.
- `mem_byte_selector` out 4: byte lanes to write.
- `mem_dataout` in 32: read data from memory. Valid at the rising edge that ends the `mem_ren` cycle.

## Operation
- States: IDLE, ACCESS, ACCESS2, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch the request.
  - Compute `off`=`addr[1:0]`, size mask `m` (B=0001, H=0011, W=1111) and the 8-bit lane mask `M`=`m<<off`.
  - A request spans two words when `M[7:4]`≠0.
- **Error checks**, in priority order, on acceptance:
  - Out of range: word index (or index+1 when spanning) ≥ MEM_WORDS → RESP with `resp_err_range`=1.
  - Misaligned (spanning) without the macro → RESP with `resp_err_misaligned`=1.
  - Range error takes priority over misaligned.
  - Neither error path asserts `mem_wen` or `mem_ren`.
- **ACCESS**: one cycle on word `w`=`addr[31:2]`.
  - Store: `mem_wen`=1, `mem_byte_selector`=`M[3:0]`, `mem_datain`=`(wdata<<8*off)[31:0]`.
  - Load: `mem_ren`=1, `mem_byte_selector`=0; capture `mem_dataout` into `lo`.
  - Go to ACCESS2 if spanning, else RESP.
- **ACCESS2**: same as ACCESS on word `w+1`.
  - Store lanes: `M[7:4]`; store data: `(wdata<<8*off)[63:32]`.
  - Load: capture into `hi`.
  - Go to RESP.
- **RESP**: `resp_valid`=1.
  - Load data = `({hi,lo}>>8*off)[31:0]`, masked to the access size.
  - LB/LH sign-extend; LBU/LHU/LW zero-extend.
  - Outputs are held stable until `resp_ready`; then go to IDLE.
- `mem_wen` and `mem_ren` are never high together. Both are 0 outside ACCESS/ACCESS2.
- Undefined funct3 values are treated as W.

## Timing
- Reset (asynchronous assert) sets:
  - state to IDLE;
  - `req_ready` to 1;
  - all other outputs, `lo` and `hi` to 0.
- A request in flight during reset is discarded, and no further memory strobes are issued.
- Aligned access:
  - Accepted at edge E0.
  - ACCESS occupies cycle E0–E1.
  - `resp_valid` rises after E1, i.e. 2 cycles after acceptance.
- Spanning access: `resp_valid` 3 cycles after acceptance.
- Error response: `resp_valid` 1 cycle after acceptance.
- Throughput: at most one request per 3 cycles when aligned with `resp_ready`=1. `req_ready` falls at the edge that accepts a request.
- Backpressure: RESP may persist any number of cycles with all outputs stable.

## Configuration
- `LSU_MISALIGNED_SPLIT_EN` defined: spanning accesses are split into ACCESS then ACCESS2. Only the necessary lanes of each word are written.
- `LSU_MISALIGNED_SPLIT_EN` undefined: ACCESS2 is not built. Any spanning access returns `resp_err_misaligned`=1 with no memory strobe.
- In both builds, accesses that are misaligned but do not span a word are legal (e.g. SB at any offset, SH at offset 1).

## Structure
- `lsu_pkg` holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the state encoding (IDLE, ACCESS, ACCESS2, RESP);
  - the default for MEM_WORDS.
- Sub-module `lsu_align` is purely combinational and computes:
  - the lane mask `M`;
  - the 64-bit shifted store data;
  - the load extract/extend from `{hi,lo}`, `off` and funct3.
- `load_store_unit` holds the FSM and the request/response registers.

## Test plan
- SW at 0x10 with 0xDEADBEEF → one cycle of `mem_wen`=1, `mem_addy`=4, selector 1111, `mem_datain`=0xDEADBEEF; `resp_valid` 2 cycles after acceptance.
- Word 4 = 0x80FF1234. LB at 0x13 → `resp_rdata` 0xFFFFFF80. LBU at 0x13 → 0x00000080. LH at 0x12 → 0xFFFF80FF.
- SH at 0x12 with 0x0000ABCD → selector 1100, `mem_datain` 0xABCD0000.
- Word 4 = 0x44332211, word 5 = 0x88776655. LW at 0x11:
  - With the macro: `mem_ren` at `mem_addy` 4 then 5, `resp_rdata` 0x55443322.
  - Without the macro: `resp_err_misaligned`=1, and `mem_ren` never asserts.
- LW at 0x1000 with MEM_WORDS=1024 → `resp_err_range`=1, `resp_rdata`=0, no strobe. Hold `resp_ready`=0 for 5 cycles → response stable.
- Drop `reset_n` during ACCESS of a store → `mem_wen` goes to 0 immediately; after release, `req_ready`=1 and `resp_valid`=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, memory size default.
// Build option LSU_MISALIGNED_SPLIT_EN enables two-word split of word-spanning accesses.
package lsu_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 1024;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ACCESS2,
        ST_RESP
    } lsu_state_e;

    // Byte mask of the access size; undefined funct3 codes fall back to a word.
    function automatic logic [3:0] size_mask(input logic wr, input logic [2:0] f3);
        logic [3:0] m;
        m = 4'b1111;
        if (wr) begin
            if (f3 == F3_SB) m = 4'b0001;
            else if (f3 == F3_SH) m = 4'b0011;
        end else begin
            if (f3 == F3_LB || f3 == F3_LBU) m = 4'b0001;
            else if (f3 == F3_LH || f3 == F3_LHU) m = 4'b0011;
        end
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane/data alignment: lane mask, shifted store data, load extract and extend.
// Shared by request acceptance (range/span checks) and the access/response states.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        wr_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] hi_i,
    output logic [7:0]  lane_mask_o,
    output logic [63:0] wdata_sh_o,
    output logic [31:0] rdata_o
);

    logic [63:0] rd_sh;

    always_comb begin
        lane_mask_o = {4'b0000, size_mask(wr_i, funct3_i)} << off_i;
        wdata_sh_o  = {32'h0, wdata_i} << {off_i, 3'b000};
        rd_sh       = {hi_i, lo_i} >> {off_i, 3'b000};
        case (funct3_i)
            F3_LB:   rdata_o = {{24{rd_sh[7]}}, rd_sh[7:0]};
            F3_LH:   rdata_o = {{16{rd_sh[15]}}, rd_sh[15:0]};
            F3_LBU:  rdata_o = {24'h0, rd_sh[7:0]};
            F3_LHU:  rdata_o = {16'h0, rd_sh[15:0]};
            default: rdata_o = rd_sh[31:0];
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, byte-lane alignment, range/misalign checks.
// LSU_MISALIGNED_SPLIT_EN: when defined, word-spanning accesses are split over two words.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err_misaligned,
    output logic        resp_err_range,
    output logic [31:0] mem_addy,
    output logic [31:0] mem_datain,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [3:0]  mem_byte_selector,
    input  logic [31:0] mem_dataout
);

    lsu_state_e  state_q, state_d;
    logic        wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, lo_q, hi_q;
    logic [4:0]  rd_q;
    logic        err_mis_q, err_rng_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic        span_q;
`endif

    logic        idle, accept, span_in, rng_in, mis_in;
    logic [31:0] idx_in;
    logic [7:0]  lane_mask;
    logic [63:0] wdata_sh;
    logic [31:0] ld_data;

    assign idle   = (state_q == ST_IDLE);
    assign accept = idle && req_valid;

    // In IDLE the aligner sees the live request so span/range are known at acceptance.
    lsu_align u_align (
        .wr_i        (idle ? req_wr     : wr_q),
        .funct3_i    (idle ? req_funct3 : f3_q),
        .off_i       (idle ? req_addr[1:0] : addr_q[1:0]),
        .wdata_i     (wdata_q),
        .lo_i        (lo_q),
        .hi_i        (hi_q),
        .lane_mask_o (lane_mask),
        .wdata_sh_o  (wdata_sh),
        .rdata_o     (ld_data)
    );

    always_comb begin
        idx_in  = {2'b00, req_addr[31:2]};
        span_in = |lane_mask[7:4];
        rng_in  = (idx_in >= MEM_WORDS) || (span_in && ((idx_in + 32'd1) >= MEM_WORDS));
`ifdef LSU_MISALIGNED_SPLIT_EN
        mis_in  = 1'b0;
`else
        mis_in  = span_in && !rng_in;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (rng_in || mis_in) ? ST_RESP : ST_ACCESS;
`ifdef LSU_MISALIGNED_SPLIT_EN
            ST_ACCESS:  state_d = span_q ? ST_ACCESS2 : ST_RESP;
            ST_ACCESS2: state_d = ST_RESP;
`else
            ST_ACCESS:  state_d = ST_RESP;
            ST_ACCESS2: state_d = ST_IDLE;
`endif
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            err_mis_q <= 1'b0;
            err_rng_q <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            span_q    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                wr_q      <= req_wr;
                f3_q      <= req_funct3;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                rd_q      <= req_rd;
                err_mis_q <= mis_in;
                err_rng_q <= rng_in;
`ifdef LSU_MISALIGNED_SPLIT_EN
                span_q    <= span_in;
`endif
            end
            if (state_q == ST_ACCESS && !wr_q)  lo_q <= mem_dataout;
            if (state_q == ST_ACCESS2 && !wr_q) hi_q <= mem_dataout;
        end
    end

    always_comb begin
        req_ready           = idle;
        resp_valid          = 1'b0;
        resp_rdata          = '0;
        resp_rd             = '0;
        resp_err_misaligned = 1'b0;
        resp_err_range      = 1'b0;
        mem_addy            = '0;
        mem_datain          = '0;
        mem_wen             = 1'b0;
        mem_ren             = 1'b0;
        mem_byte_selector   = '0;
        case (state_q)
            ST_ACCESS: begin
                mem_addy = {2'b00, addr_q[31:2]};
                mem_wen  = wr_q;
                mem_ren  = !wr_q;
                if (wr_q) begin
                    mem_byte_selector = lane_mask[3:0];
                    mem_datain        = wdata_sh[31:0];
                end
            end
            ST_ACCESS2: begin
                mem_addy = {2'b00, addr_q[31:2]} + 32'd1;
                mem_wen  = wr_q;
                mem_ren  = !wr_q;
                if (wr_q) begin
                    mem_byte_selector = lane_mask[7:4];
                    mem_datain        = wdata_sh[63:32];
                end
            end
            ST_RESP: begin
                resp_valid          = 1'b1;
                resp_rd             = rd_q;
                resp_err_misaligned = err_mis_q;
                resp_err_range      = err_rng_q;
                if (!wr_q && !err_mis_q && !err_rng_q) resp_rdata = ld_data;
            end
            default: ;
        endcase
    end

endmodule
